// File: rtl/multicycle_control.sv
// Multicycle datapath controller FSM with per-access wait timeout and sticky error state.
// Define MULTICYCLE_CONTROL_ADDI_EN to add the addi execute/writeback states (ADDIEX, ADDIWB).
module multicycle_control #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       erro,
  output logic [3:0] estado
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
  localparam logic [3:0] S_ADDIEX   = 4'd10;
  localparam logic [3:0] S_ADDIWB   = 4'd11;
`endif
  localparam logic [3:0] S_ERROR    = 4'd15;

  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [7:0] r_wait;
  logic       r_erro;
  logic       w_waiting;
  logic       w_expired;

  always_comb begin
    w_waiting = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    w_expired = w_waiting && !mem_ready && (r_wait == LP_LAST_WAIT);
    w_next    = S_ERROR;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          6'd0:         w_next = S_EXECUTE;
          6'd35, 6'd43: w_next = S_MEMADR;
          6'd4:         w_next = S_BRANCH;
          6'd2:         w_next = S_JUMP;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
          6'd8:         w_next = S_ADDIEX;
`endif
          default:      w_next = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        if (opcode == 6'd35)      w_next = S_MEMREAD;
        else if (opcode == 6'd43) w_next = S_MEMWRITE;
        else                      w_next = S_ERROR;
      end
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      S_ADDIEX:   w_next = S_ADDIWB;
      S_ADDIWB:   w_next = S_FETCH;
`endif
      default:    w_next = S_ERROR;
    endcase
    if (w_expired) w_next = S_ERROR;
  end

  // Any state change clears the counter, which covers entry into every wait state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_erro  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait <= '0;
      else if (w_waiting && !mem_ready)
        r_wait <= r_wait + 8'd1;
      if (w_next == S_ERROR)
        r_erro <= 1'b1;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = '0;
    ALUSrcB     = '0;
    ALUOp       = '0;
    erro        = 1'b0;
    estado      = '0;
    if (reset) begin
      erro   = r_erro;
      estado = r_state;
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'd1;
          PCWrite = mem_ready;
          IRWrite = mem_ready;
        end
        S_DECODE:   ALUSrcB = 2'd3;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'd2;
        end
        S_MEMREAD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'd2;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'd1;
          PCWriteCond = 1'b1;
          PCSource    = 2'd1;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'd2;
        end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'd2;
        end
        S_ADDIWB:   RegWrite = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum wait cycles in any memory state before an error is raised; legal range 1..255.
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port opcode, input, 6 bits: instruction[31:26] from the instruction register.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completes the current access in this cycle.
REQ-006 SHALL have outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst, each 1 bit: datapath enables and mux selects.
REQ-007 SHALL have outputs PCSource, ALUSrcB and ALUOp, each 2 bits; ALUOp feeds the existing ALU-control decoder (0 = add, 1 = subtract, 2 = funct-decoded).
REQ-008 SHALL have output erro, 1 bit: sticky error flag.
REQ-009 SHALL have output estado, 4 bits: current state code.

Function
REQ-010 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, ERROR=15.
REQ-011 SHALL, in FETCH, assert MemRead, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0 and PCSource=0, and assert PCWrite and IRWrite only in the cycle where mem_ready=1.
REQ-012 SHALL move FETCH->DECODE when mem_ready=1, and otherwise stay in FETCH.
REQ-013 SHALL, in DECODE, drive ALUSrcA=0, ALUSrcB=3 and ALUOp=0 (branch target), then branch on opcode: 0->EXECUTE, 35/43->MEMADR, 4->BRANCH, 2->JUMP, 8->ADDIEX; any other opcode->ERROR.
REQ-014 SHALL, in MEMADR, drive ALUSrcA=1, ALUSrcB=2 and ALUOp=0, then go to MEMREAD if opcode=35 or MEMWRITE if opcode=43.
REQ-015 SHALL, in MEMREAD, assert MemRead with IorD=1 and hold until mem_ready=1, then go to MEMWB.
REQ-016 SHALL, in MEMWRITE, assert MemWrite with IorD=1 and hold until mem_ready=1, then go to FETCH.
REQ-017 SHALL, in MEMWB, assert RegWrite with MemtoReg=1 and RegDst=0, then go to FETCH.
REQ-018 SHALL, in EXECUTE, drive ALUSrcA=1, ALUSrcB=0 and ALUOp=2, then go to ALUWB.
REQ-019 SHALL, in ALUWB, assert RegWrite with RegDst=1 and MemtoReg=0, then go to FETCH.
REQ-020 SHALL, in BRANCH, drive ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1 and PCSource=1, then go to FETCH.
REQ-021 SHALL, in JUMP, assert PCWrite with PCSource=2, then go to FETCH.
REQ-022 SHALL, in ADDIEX, drive ALUSrcA=1, ALUSrcB=2 and ALUOp=0, then go to ADDIWB.
REQ-023 SHALL, in ADDIWB, assert RegWrite with RegDst=0 and MemtoReg=0, then go to FETCH.
REQ-024 SHALL drive every output not listed for the current state to 0.
REQ-025 SHALL keep an 8-bit wait counter that clears on entry to FETCH, MEMREAD or MEMWRITE and increments on each cycle spent in one of those states with mem_ready=0.
REQ-026 SHALL go to ERROR instead of staying, when the wait counter equals TIMEOUT-1 and mem_ready=0; mem_ready=1 in that same cycle completes normally.
REQ-027 SHALL drive all control outputs to 0 and erro=1 in ERROR, and SHALL leave ERROR only by reset.
REQ-028 SHALL give latencies with zero wait states of: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.

Reset
REQ-029 SHALL, on a clock edge with reset=0, set the state to FETCH, the wait counter to 0 and erro to 0, from any state, including mid-access and ERROR.
REQ-030 SHALL drive all outputs to 0 and estado=0 while reset=0; the first cycle after release is FETCH with counter 0.

Configuration
REQ-031 SHALL, with macro MULTICYCLE_CONTROL_ADDI_EN defined, implement ADDIEX and ADDIWB as specified above.
REQ-032 SHALL, without MULTICYCLE_CONTROL_ADDI_EN, omit ADDIEX and ADDIWB and send opcode 8 from DECODE to ERROR like any illegal opcode.

Verification
REQ-033 SHALL cover: reset release, opcode=0, mem_ready=1 -> estado 0,1,6,7,0; ALUOp=2 in EXECUTE; RegWrite=1, RegDst=1 in ALUWB.
REQ-034 SHALL cover: opcode=35 with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, MemRead=1, IorD=1, then MEMWB with MemtoReg=1.
REQ-035 SHALL cover: opcode=4 -> BRANCH with ALUOp=1, PCWriteCond=1, PCSource=1; opcode=2 -> JUMP with PCWrite=1, PCSource=2.
REQ-036 SHALL cover: TIMEOUT=4 with mem_ready stuck 0 in FETCH -> ERROR after 4 cycles, erro=1, all controls 0, held until reset.
REQ-037 SHALL cover: opcode=8 -> with the macro, estado 10 then 11; without it, ERROR; reset=0 mid-MEMWRITE -> next cycle FETCH, erro=0.
